// File: rtl/gpu_noc_pkg.sv
// Shared NoC definitions for the GPU network interface.
// Flit layout: [15:10] destination node ID, [9:0] payload.
package gpu_noc_pkg;

  localparam int unsigned FLIT_W    = 16;
  localparam int unsigned DEST_MSB  = 15;
  localparam int unsigned DEST_LSB  = 10;
  localparam int unsigned PAYLOAD_W = 10;
  localparam int unsigned DEST_W    = DEST_MSB - DEST_LSB + 1;

  typedef struct packed {
    logic [DEST_W-1:0]    dest;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset; empties the FIFO
//   push_i  - write data_i (accepted when not full, or when full and popping)
//   data_i  - write data
//   pop_i   - remove head (ignored when empty)
//   data_o  - current head, valid whenever empty_o is low
//   full_o  - FIFO full
//   empty_o - FIFO empty
module noc_sync_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // One extra pointer bit distinguishes full from empty.
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot in the same cycle, so push-on-full is legal then.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/gpu_net_ni.sv
// GPU network interface: credit-based TX path to the router and a filtering
// RX path that delivers flits addressed to GPU_ID and drops the rest.
// Ports:
//   ACLK, ARESET                  - clock, synchronous active-high reset
//   gpu_data_in/valid_in/ready_out - GPU -> NI flit handshake
//   gpu_data_out/valid_out/ready_in - NI -> GPU delivery (FWFT)
//   rtr_flit_out/valid_out        - registered one-cycle flit strobe to router
//   rtr_credit_in                 - credit returned by router
//   rtr_flit_in/valid_in          - flit strobe from router
//   rtr_credit_out                - credit pulse to router, one per RX slot freed
//   drop_cnt                      - saturating count of misrouted flits
//   err_sticky                    - [0] credit overflow, [1] RX overflow
module gpu_net_ni
  import gpu_noc_pkg::*;
#(
  parameter int unsigned GPU_ID     = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CREDITS    = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [FLIT_W-1:0] gpu_data_in,
  input  logic              gpu_valid_in,
  output logic              gpu_ready_out,
  output logic [FLIT_W-1:0] gpu_data_out,
  output logic              gpu_valid_out,
  input  logic              gpu_ready_in,
  output logic [FLIT_W-1:0] rtr_flit_out,
  output logic              rtr_valid_out,
  input  logic              rtr_credit_in,
  input  logic [FLIT_W-1:0] rtr_flit_in,
  input  logic              rtr_valid_in,
  output logic              rtr_credit_out,
  output logic [15:0]       drop_cnt,
  output logic [1:0]        err_sticky
);

  localparam logic [3:0]        CreditMax = 4'(CREDITS);
  localparam logic [DEST_W-1:0] LocalId   = DEST_W'(GPU_ID);

  flit_t       tx_head, rx_head;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push_req, launch, tx_fifo_push, tx_fifo_pop;
  flit_t       launch_flit;
  logic        rx_local, rx_drop, rx_pop, rx_overflow, credit_ovf;

  logic [3:0]        credit_q, credit_d;
  logic [FLIT_W-1:0] rtr_flit_q;
  logic              rtr_valid_q, credit_out_q;
  logic [15:0]       drop_q;
  logic [1:0]        err_q;

  // ---------------- TX path ----------------
  assign gpu_ready_out = !tx_full;
  assign tx_push_req   = gpu_valid_in && !tx_full;
  assign launch        = (credit_q != 4'd0) && (!tx_empty || tx_push_req);
  // With an empty FIFO the incoming flit bypasses storage so it launches at N+1.
  assign launch_flit   = tx_empty ? flit_t'(gpu_data_in) : tx_head;
  assign tx_fifo_push  = tx_push_req && !(tx_empty && launch);
  assign tx_fifo_pop   = launch && !tx_empty;

  noc_sync_fifo #(
    .Width (FLIT_W),
    .Depth (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .push_i  (tx_fifo_push),
    .data_i  (gpu_data_in),
    .pop_i   (tx_fifo_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  always_comb begin
    credit_d   = credit_q;
    credit_ovf = 1'b0;
    if (launch && !rtr_credit_in) begin
      credit_d = credit_q - 4'd1;
    end else if (rtr_credit_in && !launch) begin
      if (credit_q == CreditMax) credit_ovf = 1'b1;
      else                       credit_d   = credit_q + 4'd1;
    end
  end

  // ---------------- RX path ----------------
  assign rx_local      = (rx_head.dest == LocalId);
  assign gpu_valid_out = !rx_empty && rx_local;
  assign gpu_data_out  = rx_head;
  assign rx_drop       = !rx_empty && !rx_local;
  assign rx_pop        = (gpu_valid_out && gpu_ready_in) || rx_drop;
  // The FIFO silently ignores this push; flag it and still return the credit.
  assign rx_overflow   = rtr_valid_in && rx_full && !rx_pop;

  noc_sync_fifo #(
    .Width (FLIT_W),
    .Depth (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .push_i  (rtr_valid_in),
    .data_i  (rtr_flit_in),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // ---------------- State ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      credit_q     <= CreditMax;
      rtr_flit_q   <= '0;
      rtr_valid_q  <= 1'b0;
      credit_out_q <= 1'b0;
      drop_q       <= '0;
      err_q        <= '0;
    end else begin
      credit_q     <= credit_d;
      rtr_valid_q  <= launch;
      credit_out_q <= rx_pop || rx_overflow;
      if (launch) rtr_flit_q <= launch_flit;
      if (rx_drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      err_q <= err_q | {rx_overflow, credit_ovf};
    end
  end

  assign rtr_flit_out   = rtr_flit_q;
  assign rtr_valid_out  = rtr_valid_q;
  assign rtr_credit_out = credit_out_q;
  assign drop_cnt       = drop_q;
  assign err_sticky     = err_q;

endmodule

// File: tb/tb_gpu_net_ni.sv
module tb_gpu_net_ni;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] gpu_data_in;
  logic        gpu_valid_in;
  logic        gpu_ready_out;
  logic [15:0] gpu_data_out;
  logic        gpu_valid_out;
  logic        gpu_ready_in;
  logic [15:0] rtr_flit_out;
  logic        rtr_valid_out;
  logic        rtr_credit_in;
  logic [15:0] rtr_flit_in;
  logic        rtr_valid_in;
  logic        rtr_credit_out;
  logic [15:0] drop_cnt;
  logic [1:0]  err_sticky;

  int n_checks = 0;
  int n_pass   = 0;

  gpu_net_ni #(
    .GPU_ID     (6),
    .FIFO_DEPTH (4),
    .CREDITS    (4)
  ) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .gpu_data_in    (gpu_data_in),
    .gpu_valid_in   (gpu_valid_in),
    .gpu_ready_out  (gpu_ready_out),
    .gpu_data_out   (gpu_data_out),
    .gpu_valid_out  (gpu_valid_out),
    .gpu_ready_in   (gpu_ready_in),
    .rtr_flit_out   (rtr_flit_out),
    .rtr_valid_out  (rtr_valid_out),
    .rtr_credit_in  (rtr_credit_in),
    .rtr_flit_in    (rtr_flit_in),
    .rtr_valid_in   (rtr_valid_in),
    .rtr_credit_out (rtr_credit_out),
    .drop_cnt       (drop_cnt),
    .err_sticky     (err_sticky)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " gpu_ready_out"},  32'(gpu_ready_out),  32'd1);
    chk({tag, " rtr_valid_out"},  32'(rtr_valid_out),  32'd0);
    chk({tag, " rtr_credit_out"}, 32'(rtr_credit_out), 32'd0);
    chk({tag, " gpu_valid_out"},  32'(gpu_valid_out),  32'd0);
    chk({tag, " rtr_flit_out"},   32'(rtr_flit_out),   32'd0);
    chk({tag, " drop_cnt"},       32'(drop_cnt),       32'd0);
    chk({tag, " err_sticky"},     32'(err_sticky),     32'd0);
    chk({tag, " credit_cnt"},     32'(dut.credit_q),   32'd4);
  endtask

  initial begin
    ARESET        = 1'b1;
    gpu_data_in   = '0;
    gpu_valid_in  = 1'b0;
    gpu_ready_in  = 1'b0;
    rtr_credit_in = 1'b0;
    rtr_flit_in   = '0;
    rtr_valid_in  = 1'b0;
    tick();
    tick();
    ARESET = 1'b0;
    chk_reset_outputs("reset");

    // Single push with an empty FIFO launches on the next cycle.
    gpu_data_in  = 16'h1D23;
    gpu_valid_in = 1'b1;
    tick();
    gpu_valid_in = 1'b0;
    chk("single valid",  32'(rtr_valid_out), 32'd1);
    chk("single flit",   32'(rtr_flit_out),  32'h1D23);
    chk("single credit", 32'(dut.credit_q),  32'd3);
    tick();
    chk("single valid low", 32'(rtr_valid_out), 32'd0);
    rtr_credit_in = 1'b1;
    tick();
    rtr_credit_in = 1'b0;
    chk("credit back", 32'(dut.credit_q), 32'd4);

    // Six back-to-back pushes, four credits.
    for (int i = 0; i < 6; i++) begin
      gpu_data_in  = 16'h0100 + 16'(i);
      gpu_valid_in = 1'b1;
      tick();
      chk($sformatf("burst valid %0d", i), 32'(rtr_valid_out), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) chk($sformatf("burst flit %0d", i), 32'(rtr_flit_out), 32'h0100 + 32'(i));
    end
    gpu_valid_in = 1'b0;
    chk("burst ready", 32'(gpu_ready_out), 32'd1);
    chk("burst credit0", 32'(dut.credit_q), 32'd0);
    tick();
    chk("burst stalled", 32'(rtr_valid_out), 32'd0);
    rtr_credit_in = 1'b1;
    tick();
    rtr_credit_in = 1'b0;
    chk("credit arrive no launch", 32'(rtr_valid_out), 32'd0);
    chk("credit arrive cnt", 32'(dut.credit_q), 32'd1);
    tick();
    chk("extra launch valid", 32'(rtr_valid_out), 32'd1);
    chk("extra launch flit",  32'(rtr_flit_out),  32'h0104);
    chk("extra launch cnt",   32'(dut.credit_q),  32'd0);
    tick();
    chk("only one extra", 32'(rtr_valid_out), 32'd0);

    // Credit in with launch in the same cycle leaves the count unchanged.
    rtr_credit_in = 1'b1;
    tick();
    chk("pre-simul cnt", 32'(dut.credit_q), 32'd1);
    tick();
    chk("simul launch flit", 32'(rtr_flit_out),  32'h0105);
    chk("simul launch valid", 32'(rtr_valid_out), 32'd1);
    chk("simul credit cnt",  32'(dut.credit_q),  32'd1);
    tick();
    tick();
    tick();
    chk("credit refilled", 32'(dut.credit_q), 32'd4);
    chk("no ovf yet", 32'(err_sticky), 32'd0);
    tick();
    rtr_credit_in = 1'b0;
    chk("credit hold max", 32'(dut.credit_q), 32'd4);
    chk("credit ovf flag", 32'(err_sticky), 32'd1);

    // RX filter: local flit delivered, remote flit dropped.
    rtr_flit_in  = 16'h1955;
    rtr_valid_in = 1'b1;
    tick();
    chk("rx local valid", 32'(gpu_valid_out), 32'd1);
    chk("rx local data",  32'(gpu_data_out),  32'h1955);
    rtr_flit_in = 16'h0855;
    tick();
    rtr_valid_in = 1'b0;
    chk("rx no credit yet", 32'(rtr_credit_out), 32'd0);
    gpu_ready_in = 1'b1;
    tick();
    gpu_ready_in = 1'b0;
    chk("rx deliver credit", 32'(rtr_credit_out), 32'd1);
    chk("rx remote hidden", 32'(gpu_valid_out), 32'd0);
    tick();
    chk("rx drop credit", 32'(rtr_credit_out), 32'd1);
    chk("rx drop cnt", 32'(drop_cnt), 32'd1);
    chk("rx empty", 32'(gpu_valid_out), 32'd0);
    tick();
    chk("rx credit ends", 32'(rtr_credit_out), 32'd0);

    // RX overflow: 5 strobes into a 4-deep FIFO, then push-with-pop on full.
    for (int i = 0; i < 5; i++) begin
      rtr_flit_in  = 16'h1800 + 16'(i);
      rtr_valid_in = 1'b1;
      tick();
      if (i == 3) chk("ovf pre credit", 32'(rtr_credit_out), 32'd0);
    end
    chk("ovf credit pulse", 32'(rtr_credit_out), 32'd1);
    chk("ovf err", 32'(err_sticky), 32'd3);
    rtr_flit_in  = 16'h1805;
    gpu_ready_in = 1'b1;
    chk("full head", 32'(gpu_data_out), 32'h1800);
    tick();
    rtr_valid_in = 1'b0;
    chk("full push+pop credit", 32'(rtr_credit_out), 32'd1);
    chk("full push+pop head", 32'(gpu_data_out), 32'h1801);
    tick();
    chk("drain 1802", 32'(gpu_data_out), 32'h1802);
    tick();
    chk("drain 1803", 32'(gpu_data_out), 32'h1803);
    tick();
    chk("drain 1805", 32'(gpu_data_out), 32'h1805);
    chk("drain valid", 32'(gpu_valid_out), 32'd1);
    tick();
    gpu_ready_in = 1'b0;
    chk("drained", 32'(gpu_valid_out), 32'd0);

    // Reset mid-transfer.
    gpu_data_in  = 16'h0300;
    gpu_valid_in = 1'b1;
    tick();
    chk("pre-reset launch", 32'(rtr_valid_out), 32'd1);
    rtr_flit_in  = 16'h1900;
    rtr_valid_in = 1'b1;
    ARESET       = 1'b1;
    tick();
    ARESET       = 1'b0;
    gpu_valid_in = 1'b0;
    rtr_valid_in = 1'b0;
    chk_reset_outputs("midreset");
    tick();
    chk("post-reset rx empty", 32'(gpu_valid_out), 32'd0);
    chk("post-reset no launch", 32'(rtr_valid_out), 32'd0);
    chk("post-reset no credit", 32'(rtr_credit_out), 32'd0);
    chk("post-reset drop", 32'(drop_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpu_net_ni.md
GPU_NET_NI -- requirements
Module: gpu_net_ni

Interface
REQ-001 Parameter GPU_ID, default 6; local node ID, compared with flit bits [15:10].
REQ-002 Parameter FIFO_DEPTH, default 4; entries per TX and RX FIFO, power of two, at least 2.
REQ-003 Parameter CREDITS, default 4; initial and maximum router credits, at most 15.
REQ-004 ACLK  in  1  sole clock; all state updates on rising edge.
REQ-005 ARESET  in  1  reset, synchronous and active-high.
REQ-006 gpu_data_in  in  16  flit from GPU, bits [15:10] dest, bits [9:0] payload.
REQ-007 gpu_valid_in  in  1  GPU flit valid.
REQ-008 gpu_ready_out  out  1  NI can accept a GPU flit (drives GPU net_ready_in).
REQ-009 gpu_data_out  out  16  flit delivered to GPU.
REQ-010 gpu_valid_out  out  1  delivered flit valid.
REQ-011 gpu_ready_in  in  1  GPU accepts delivered flit.
REQ-012 rtr_flit_out  out  16  flit to router.
REQ-013 rtr_valid_out  out  1  one-cycle flit strobe to router.
REQ-014 rtr_credit_in  in  1  one-cycle credit return from router.
REQ-015 rtr_flit_in  in  16  flit from router.
REQ-016 rtr_valid_in  in  1  one-cycle flit strobe from router.
REQ-017 rtr_credit_out  out  1  one-cycle credit return to router.
REQ-018 drop_cnt  out  16  count of misrouted flits discarded, saturating.
REQ-019 err_sticky  out  2  bit0 credit overflow, bit1 RX overflow; sticky until reset.

Function
REQ-020 TX push SHALL occur when gpu_valid_in && gpu_ready_out.
- gpu_ready_out SHALL equal !tx_full, derived from registered state only.
REQ-021 TX launch SHALL occur when the TX FIFO is non-empty and credit_cnt > 0.
- Launch pops the head into the rtr_flit_out register.
- rtr_valid_out SHALL be high for exactly that following cycle, then low.
REQ-022 A flit pushed in cycle N SHALL appear on rtr_flit_out no earlier than cycle N+1.
- With credits available and an empty FIFO, it SHALL appear at exactly N+1.
- Sustained throughput SHALL be one flit per cycle.
REQ-023 credit_cnt (4 bit) update rules:
- launch only: decrement.
- rtr_credit_in only: increment.
- both in the same cycle: unchanged.
- increment at CREDITS: hold at CREDITS and set err_sticky[0].
REQ-024 Every rtr_valid_in SHALL push rtr_flit_in into the RX FIFO unconditionally.
- If the RX FIFO is full: discard the flit, set err_sticky[1], pulse rtr_credit_out next cycle.
REQ-025 RX head with dest == GPU_ID: presented first-word-fall-through.
- gpu_valid_out = !rx_empty.
- gpu_data_out = head.
- Pop on gpu_valid_out && gpu_ready_in.
REQ-026 RX head with dest != GPU_ID: popped automatically in the cycle it reaches the head.
- gpu_valid_out stays low for that head.
- drop_cnt increments, saturating at 16'hFFFF.
REQ-027 rtr_credit_out SHALL pulse high in the cycle after each RX pop, whether delivered or dropped.
- At most one RX pop occurs per cycle.
REQ-028 A simultaneous RX push and pop on a full RX FIFO SHALL be accepted with no overflow.
- Same rule applies to TX.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
- Full/empty SHALL use one extra pointer bit.

Reset
REQ-030 On ARESET at any clock edge, including mid-transfer, the following SHALL apply on the next cycle:
- Both FIFOs empty.
- credit_cnt = CREDITS.
- rtr_valid_out = 0, rtr_credit_out = 0, gpu_valid_out = 0.
- drop_cnt = 0, err_sticky = 0.
- rtr_flit_out = 0.
- gpu_ready_out = 1.
REQ-031 In-flight FIFO contents SHALL be discarded on reset; no credit is returned for them.

Structure
REQ-032 Package gpu_noc_pkg SHALL hold:
- FLIT_W=16, DEST_MSB=15, DEST_LSB=10, PAYLOAD_W=10.
- The flit typedef.
REQ-033 One sub-module, noc_sync_fifo (parameterised width/depth, FWFT), SHALL be instantiated twice: TX and RX.

Verification
REQ-034 Reset, then push 16'h1D23 at cycle 0 with CREDITS=4 -> rtr_flit_out=16'h1D23 with rtr_valid_out high at cycle 1 only; credit_cnt=3.
REQ-035 Push 6 flits back-to-back with no credit return -> 4 launched, then rtr_valid_out low.
- TX holds 2 flits; gpu_ready_out remains high.
- One rtr_credit_in pulse -> exactly one further launch.
REQ-036 Router sends 16'h1955 (dest 6) and 16'h0855 (dest 2) -> GPU receives only 16'h1955.
- drop_cnt=1.
- rtr_credit_out pulses twice.
REQ-037 gpu_ready_in held low, 5 rtr_valid_in strobes -> first 4 stored, 5th discarded, err_sticky[1]=1.
REQ-038 Launch and rtr_credit_in in the same cycle -> credit_cnt unchanged.
- rtr_credit_in with credit_cnt=4 -> stays 4, err_sticky[0]=1.
- ARESET asserted mid-burst -> all outputs match REQ-030 on the next cycle.
